// File: rtl/mdu_hazard_tracker_pkg.sv
// rtl/mdu_hazard_tracker_pkg.sv - shared types, widths and match helper for the md hazard tracker
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif
`ifndef DIV_LAT
`define DIV_LAT 33
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

package mdu_hazard_tracker_pkg;

    localparam int REG_ADDR_W = `REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 never creates a dependency; with check_en clear the enable is ignored
    function automatic logic reg_match(
        input logic      en,
        input reg_addr_t addr,
        input reg_addr_t pend,
        input logic      check_en
    );
        return (addr != '0) && (addr == pend) && (en || !check_en);
    endfunction

endpackage

// File: rtl/div_occupancy_ctr.sv
// rtl/div_occupancy_ctr.sv - divider occupancy down-counter with destination latch and wb decode
module div_occupancy_ctr
    import mdu_hazard_tracker_pkg::*;
#(
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue,
    input  logic [4:0]       i_rd,
    output logic [CNT_W-1:0] o_cnt,
    output logic [4:0]       o_rd,
    output logic             o_busy,
    output logic             o_wb_valid
);

    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd;

    // a new issue reloads even if the previous divide is still counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_rd  <= '0;
        end else if (i_issue) begin
            r_cnt <= CNT_W'(DIV_LAT);
            r_rd  <= i_rd;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_rd       = r_rd;
    assign o_busy     = (r_cnt != '0);
    assign o_wb_valid = (r_cnt == CNT_W'(1)) && (r_rd != '0);

endmodule

// File: rtl/mdu_hazard_tracker.sv
// rtl/mdu_hazard_tracker.sv - tracks in-flight mul/div results and raises the ID-stage stall
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif
`ifndef DIV_LAT
`define DIV_LAT 33
`endif

module mdu_hazard_tracker
    import mdu_hazard_tracker_pkg::*;
#(
    parameter int MULT_LAT = `MULT_PPL_STAGE,
    parameter int DIV_LAT  = `DIV_LAT,
    parameter int CHECK_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rs1_re_id_i,
    input  logic                rs2_re_id_i,
    input  logic                rd_we_id_i,
    input  logic [4:0]          rs1_addr_id_i,
    input  logic [4:0]          rs2_addr_id_i,
    input  logic [4:0]          rd_addr_id_i,
    input  logic                md_id_i,
    input  logic                div_id_i,
    input  logic                issue_i,
    input  logic                issue_div_i,
    input  logic [4:0]          issue_rd_i,
    output logic                stall_o,
    output logic [MULT_LAT-1:0] mult_busy_o,
    output logic                div_busy_o,
    output logic                wb_valid_o,
    output logic [4:0]          wb_rd_o,
    output logic                wb_div_o
);

    localparam int   CNT_W  = $clog2(DIV_LAT + 1);
    localparam logic W_CHK  = (CHECK_EN != 0);

    logic [MULT_LAT-1:0]      r_mult_valid;
    logic [MULT_LAT-1:0][4:0] r_mult_rd;

    logic             w_mult_load;
    logic             w_mult_wb;
    logic [CNT_W-1:0] w_div_cnt;
    logic [4:0]       w_div_rd;
    logic             w_div_busy;
    logic             w_div_wb;
    logic             w_hazard;
    logic             w_struct;
    logic             w_collide;

    assign w_mult_load = issue_i && !issue_div_i && (issue_rd_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mult_valid <= '0;
            r_mult_rd    <= '0;
        end else begin
            r_mult_valid[0] <= w_mult_load;
            r_mult_rd[0]    <= w_mult_load ? issue_rd_i : 5'd0;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_mult_valid[i] <= r_mult_valid[i-1];
                r_mult_rd[i]    <= r_mult_rd[i-1];
            end
        end
    end

    div_occupancy_ctr #(
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_div_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (issue_i && issue_div_i),
        .i_rd       (issue_rd_i),
        .o_cnt      (w_div_cnt),
        .o_rd       (w_div_rd),
        .o_busy     (w_div_busy),
        .o_wb_valid (w_div_wb)
    );

    function automatic logic id_hits(input logic [4:0] pend);
        return reg_match(rs1_re_id_i, rs1_addr_id_i, pend, W_CHK)
            || reg_match(rs2_re_id_i, rs2_addr_id_i, pend, W_CHK)
            || reg_match(rd_we_id_i,  rd_addr_id_i,  pend, W_CHK);
    endfunction

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
            if (r_mult_valid[i] && id_hits(r_mult_rd[i])) begin
                w_hazard = 1'b1;
            end
        end
        if (w_div_busy && (w_div_rd != '0) && id_hits(w_div_rd)) begin
            w_hazard = 1'b1;
        end
    end

    // a mult issued now would retire in the same cycle as the pending divide
    assign w_collide = md_id_i && !div_id_i && (w_div_cnt == CNT_W'(MULT_LAT + 1));
    assign w_struct  = md_id_i && div_id_i && w_div_busy;
    assign stall_o   = w_hazard || w_struct || w_collide;

    assign w_mult_wb   = r_mult_valid[MULT_LAT-1];
    assign mult_busy_o = r_mult_valid;
    assign div_busy_o  = w_div_busy;
    assign wb_valid_o  = w_mult_wb || w_div_wb;
    assign wb_rd_o     = w_mult_wb ? r_mult_rd[MULT_LAT-1] : (w_div_wb ? w_div_rd : 5'd0);
    assign wb_div_o    = !w_mult_wb && w_div_wb;

    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst) !(issue_i && stall_o));

endmodule
